// File: rtl/i2s_rx_capture.sv
// i2s_rx_capture: four-channel I2S receiver for a shared-BCLK/WS INMP441 array.
// Captures the 24-bit left-slot sample of every mic in the same frame and
// presents them as one phase-aligned word on a valid/ready interface.
//
// Ports:
//   clk, rst_n     system clock, synchronous active-low reset
//   bclk, ws, sd   I2S bit clock, word select (0 = left), per-mic serial data
//   sample_data    mic i at [i*SAMPLE_BITS +: SAMPLE_BITS]
//   sample_valid   sample_data holds an unconsumed frame
//   sample_ready   consumer accepts when high together with sample_valid
//   overrun        one-clk pulse when a completed frame is dropped
//   frame_err      one-clk pulse on a WS edge at an unexpected bit position
//
// Optional feature: define I2S_RX_INPUT_SYNC_EN to put a 2-flop synchroniser
// ahead of the snapshot stage (for an asynchronous BCLK master, +2 clk latency).
module i2s_rx_capture #(
  parameter int unsigned N_MICS      = 4,
  parameter int unsigned SAMPLE_BITS = 24,
  parameter int unsigned BITS_PER_CH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bclk,
  input  logic                          ws,
  input  logic [N_MICS-1:0]             sd,
  output logic [N_MICS*SAMPLE_BITS-1:0] sample_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic                          overrun,
  output logic                          frame_err
);

  localparam int unsigned DataW = N_MICS * SAMPLE_BITS;
  localparam int unsigned CntW  = (BITS_PER_CH > 1) ? $clog2(BITS_PER_CH) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(BITS_PER_CH - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(SAMPLE_BITS - 1);

  typedef enum logic [1:0] {StSeek, StLeftData, StLeftPad, StRight} state_e;

  logic              in_bclk, in_ws;
  logic [N_MICS-1:0] in_sd;

`ifdef I2S_RX_INPUT_SYNC_EN
  logic [N_MICS+1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bclk, ws, sd};
      sync2_q <= sync1_q;
    end
  end

  assign {in_bclk, in_ws, in_sd} = sync2_q;
`else
  assign {in_bclk, in_ws, in_sd} = {bclk, ws, sd};
`endif

  // Snapshot stage: all three inputs registered together.
  logic              bclk_q, ws_q, bclk_prev_q;
  logic [N_MICS-1:0] sd_q;

  state_e            state_q, state_d;
  logic              ws_last_q, ws_last_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DataW-1:0]  shift_q, shift_d;
  logic [DataW-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;

  logic rise, boundary, load_frame;

  assign rise     = bclk_q & ~bclk_prev_q;
  assign boundary = rise & (ws_q != ws_last_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bclk_q      <= 1'b0;
      ws_q        <= 1'b0;
      sd_q        <= '0;
      bclk_prev_q <= 1'b0;
      state_q     <= StSeek;
      ws_last_q   <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bclk_q      <= in_bclk;
      ws_q        <= in_ws;
      sd_q        <= in_sd;
      bclk_prev_q <= bclk_q;
      state_q     <= state_d;
      ws_last_q   <= ws_last_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ws_last_d   = ws_last_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    load_frame  = 1'b0;

    if (valid_q && sample_ready) valid_d = 1'b0;

    if (rise) begin
      ws_last_d = ws_q;
      if (boundary)                bit_cnt_d = '0;
      else if (bit_cnt_q != CntMax) bit_cnt_d = bit_cnt_q + CntW'(1);

      if (boundary && (state_q != StSeek) && (bit_cnt_q != CntMax)) begin
        // Misplaced WS edge: drop partial data and re-evaluate the edge as SEEK
        // would, so a ws=0 edge starts a fresh capture right away.
        frame_err_d = 1'b1;
        shift_d     = '0;
        state_d     = ws_q ? StSeek : StLeftData;
      end else begin
        unique case (state_q)
          StSeek: begin
            if (boundary && !ws_q) state_d = StLeftData;
          end
          StLeftData: begin
            // Any boundary here is a mismatch (count < BITS_PER_CH-1), handled above.
            for (int unsigned i = 0; i < N_MICS; i++) begin
              shift_d[i*SAMPLE_BITS +: SAMPLE_BITS] =
                {shift_q[i*SAMPLE_BITS +: SAMPLE_BITS-1], sd_q[i]};
            end
            if (bit_cnt_q == CntLast) begin
              load_frame = 1'b1;
              state_d    = StLeftPad;
            end
          end
          StLeftPad: begin
            if (boundary && ws_q) state_d = StRight;
          end
          StRight: begin
            if (boundary && !ws_q) state_d = StLeftData;
          end
        endcase
      end
    end

    if (load_frame) begin
      if (!valid_q || sample_ready) begin
        data_d  = shift_d;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2s_rx_capture.sv
module tb_i2s_rx_capture;

`ifdef I2S_RX_INPUT_SYNC_EN
  localparam int Lat = 4;
`else
  localparam int Lat = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bclk, ws;
  logic [3:0]  sd;
  logic [95:0] sample_data;
  logic        sample_valid, sample_ready, overrun, frame_err;

  i2s_rx_capture dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bclk         (bclk),
    .ws           (ws),
    .sd           (sd),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int half  = 48;
  int last_bit_cyc = 0;
  int ovr_cnt  = 0;
  int ferr_cnt = 0;

  typedef struct {
    logic [95:0] data;
    bit          chk_lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] mk(input logic [23:0] base);
    logic [95:0] r;
    for (int i = 0; i < 4; i++) r[i*24 +: 24] = base + 24'(i);
    return r;
  endfunction

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [95:0] d, input bit lat);
    exp_t e;
    e.data    = d;
    e.chk_lat = lat;
    exp_q.push_back(e);
  endtask

  // I2S transmitter: period j carries data bit 24-j for j=1..24 (one-bit delay).
  task automatic send_slot(input logic ws_v, input logic [95:0] w, input int first,
                           input int last);
    logic [3:0] s;
    for (int j = first; j < last; j++) begin
      s = '0;
      if (j >= 1 && j <= 24) begin
        for (int i = 0; i < 4; i++) s[i] = w[i*24 + 24 - j];
      end
      bclk = 1'b0;
      ws   = ws_v;
      sd   = s;
      repeat (half) wait_clk();
      bclk = 1'b1;
      if (j == 24 && !ws_v) last_bit_cyc = cyc;
      repeat (half) wait_clk();
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_word: got %h, expected no word", sample_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word", sample_data, e.data);
        if (e.chk_lat) check("valid_latency", 96'(cyc - last_bit_cyc), 96'(Lat));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && overrun)   ovr_cnt++;
    if (rst_n && frame_err) ferr_cnt++;
  end

  localparam logic [95:0] RightW = {4{24'hFFFFFF}};
  localparam logic [95:0] WordB  = {24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h800000};

  initial begin
    rst_n = 1'b0;
    bclk = 1'b0;
    ws = 1'b0;
    sd = '0;
    sample_ready = 1'b1;
    repeat (3) wait_clk();
    check("rst_valid", 96'(sample_valid), 96'(0));
    check("rst_data", sample_data, 96'(0));
    check("rst_overrun", 96'(overrun), 96'(0));
    check("rst_frame_err", 96'(frame_err), 96'(0));
    rst_n = 1'b1;
    wait_clk();

    // Compliant frames at half-period 48.
    half = 48;
    send_slot(1'b1, RightW, 0, 32);
    push(mk(24'h123456), 1'b1);
    check("word_a_const", mk(24'h123456),
          {24'h123459, 24'h123458, 24'h123457, 24'h123456});
    send_slot(1'b0, mk(24'h123456), 0, 32);
    send_slot(1'b1, RightW, 0, 32);

    // Extreme values, faster BCLK.
    half = 3;
    push(WordB, 1'b1);
    send_slot(1'b0, WordB, 0, 32);
    send_slot(1'b1, RightW, 0, 32);

    // Backpressure: second frame is dropped.
    sample_ready = 1'b0;
    push(mk(24'hA5A5A0), 1'b0);
    send_slot(1'b0, mk(24'hA5A5A0), 0, 32);
    send_slot(1'b1, RightW, 0, 32);
    send_slot(1'b0, mk(24'h5A5A50), 0, 32);
    send_slot(1'b1, RightW, 0, 32);
    check("overrun_count", 96'(ovr_cnt), 96'(1));
    check("held_valid", 96'(sample_valid), 96'(1));
    sample_ready = 1'b1;
    wait_clk();
    check("valid_fall", 96'(sample_valid), 96'(0));

    // Short left slot: WS toggles after 20 rises.
    send_slot(1'b0, mk(24'h111111), 0, 20);
    send_slot(1'b1, RightW, 0, 32);
    check("frame_err_count", 96'(ferr_cnt), 96'(1));
    push(mk(24'h0F0F00), 1'b1);
    send_slot(1'b0, mk(24'h0F0F00), 0, 32);
    send_slot(1'b1, RightW, 0, 32);

    // Reset mid LEFT_DATA while a word is held.
    sample_ready = 1'b0;
    send_slot(1'b0, mk(24'h654321), 0, 32);
    send_slot(1'b1, RightW, 0, 32);
    send_slot(1'b0, mk(24'hABCDE0), 0, 10);
    rst_n = 1'b0;
    wait_clk();
    check("midrst_valid", 96'(sample_valid), 96'(0));
    check("midrst_data", sample_data, 96'(0));
    check("midrst_overrun", 96'(overrun), 96'(0));
    check("midrst_frame_err", 96'(frame_err), 96'(0));
    rst_n = 1'b1;
    sample_ready = 1'b1;
    send_slot(1'b0, mk(24'hABCDE0), 10, 32);
    send_slot(1'b1, RightW, 0, 32);
    push(mk(24'hC3C3C0), 1'b1);
    send_slot(1'b0, mk(24'hC3C3C0), 0, 32);
    send_slot(1'b1, RightW, 0, 32);

    repeat (10) wait_clk();
    check("queue_drained", 96'(exp_q.size()), 96'(0));
    check("overrun_total", 96'(ovr_cnt), 96'(1));
    check("frame_err_total", 96'(ferr_cnt), 96'(1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_rx_capture.md
# i2s_rx_capture

Four-channel I2S receiver that consumes the shared BCLK/WS pair driven to the INMP441 array and deserialises each microphone's SD line. It captures the 24-bit left-slot sample from every mic in the same frame and presents all four as one word. The word goes out on a valid/ready interface to the downstream beamformer front end. Because all mics share BCLK/WS, the samples in one output word are phase-aligned by construction.

## Interface
- `N_MICS`, 4, number of SD lines, one mic each, all strapped to left channel.
- `SAMPLE_BITS`, 24, significant bits captured per slot, MSB first, two's complement.
- `BITS_PER_CH`, 32, BCLK periods per WS half-frame; must be > `SAMPLE_BITS`.
- `clk` in 1: system clock, same domain as the BCLK/WS generator.
- `rst_n` in 1: synchronous, active-low reset.
- `bclk` in 1: I2S bit clock.
- `ws` in 1: I2S word select; 0 = left slot.
- `sd` in `N_MICS`: serial data, bit i from mic i.
- `sample_data` out `N_MICS*SAMPLE_BITS`: mic i occupies `[i*SAMPLE_BITS +: SAMPLE_BITS]`.
- `sample_valid` out 1: `sample_data` holds an unconsumed frame.
- `sample_ready` in 1: consumer accepts when high with `sample_valid`.
- `overrun` out 1: one-clk pulse when a completed frame is dropped.
- `frame_err` out 1: one-clk pulse on a WS edge at an unexpected bit position.

## Operation
- Input stage: `bclk`, `ws` and `sd` are registered together in one stage, giving a consistent snapshot.
- BCLK rise = snapshot bclk 1 while the previous snapshot was 0.
- All protocol logic advances only on detected rises.
- WS boundary = a rise whose sampled ws differs from ws sampled at the previous rise.
- The boundary rise's SD is ignored, per the I2S one-bit delay. The next rise carries the MSB.
- Rise counter `bit_cnt`, 0..`BITS_PER_CH`-1:
  - cleared at a boundary;
  - incremented on every other rise;
  - saturates at `BITS_PER_CH`-1.
- FSM states:
  - SEEK (reset state): wait for a boundary with ws=0, then go to LEFT_DATA. Other boundaries are ignored with no frame_err.
  - LEFT_DATA: on each rise, shift each `sd[i]` into the LSB of shift register i. After `SAMPLE_BITS` data rises, perform the output load and go to LEFT_PAD.
  - LEFT_PAD: ignore SD. A boundary with ws=1 goes to RIGHT.
  - RIGHT: ignore SD. A boundary with ws=0 goes to LEFT_DATA.
- Frame check, applied outside SEEK: at every boundary, `bit_cnt` must equal `BITS_PER_CH`-1.
  - On mismatch, pulse `frame_err`, discard any partial shift data and go to SEEK.
  - That boundary is itself evaluated by SEEK, so a ws=0 mismatch boundary starts capture immediately.
- Output load, when the last data bit is shifted:
  - If `!sample_valid` or `sample_ready`: load `sample_data` and set `sample_valid`=1.
  - Otherwise: keep the old data and valid, drop the new frame and pulse `overrun`.
- Handshake:
  - `sample_valid` falls the clk after `sample_valid && sample_ready`, unless a load occurs in that same clk; then it stays 1 with the new data.
  - `sample_data` is stable while valid.
- Reset values: `sample_data`=0, `sample_valid`=0, `overrun`=0, `frame_err`=0, FSM=SEEK, `bit_cnt`=0, shift registers=0, input snapshots=0.
- Reset asserted mid-slot abandons the slot. Capture resumes only after a fresh ws 1→0 boundary.

## Timing
- BCLK high and low phases must each be ≥2 clk. The block never misses a rise under that condition.
- Rise detection occurs 1 clk after `bclk` goes high at the port (2 clk with the sync option).
- `sample_valid` rises 1 clk after the clk in which the rise carrying bit `SAMPLE_BITS`-1 is detected.
- `overrun` and `frame_err` are asserted for exactly the clk following the detecting rise.
- Throughput: one word per WS period (2·`BITS_PER_CH` BCLK).

## Configuration
- `I2S_RX_INPUT_SYNC_EN` defined: `bclk`, `ws` and `sd` pass through a 2-flop synchroniser (reset to 0) ahead of the snapshot stage. Use this for an external or asynchronous BCLK master. All latencies grow by 2 clk.
- `I2S_RX_INPUT_SYNC_EN` undefined: single register stage only; the inputs must come from the same `clk` domain.

## Test plan
- Compliant frames, default parameters, BCLK half-period 48 clk. Mic i left = 24'h123456+i, right = 24'hFFFFFF → after the first ws 1→0 boundary, `sample_data` = {24'h123459, 24'h123458, 24'h123457, 24'h123456}. `sample_valid` rises 1 clk after the bit-23 rise is detected. Right-slot data is never seen.
- Mic0 left = 24'h800000, others 24'h7FFFFF → fields match exactly; no sign extension or truncation errors.
- `sample_ready`=0 for two frames → first word held. `overrun` pulses once at the second frame's bit 23 with data unchanged. Raise ready → `sample_valid` falls the next clk.
- WS toggles after 20 rises inside a left slot → one `frame_err` pulse and no valid for that slot. The next valid word is correct after a compliant ws 1→0 boundary.
- `rst_n` low for 1 clk mid LEFT_DATA → all outputs 0 next clk. No word is produced until a ws 1→0 boundary is seen, and that word is correct.
- `I2S_RX_INPUT_SYNC_EN` defined, same stimulus as the first scenario → identical data, `sample_valid` 2 clk later.
